// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one full-subtractor cell reused across WIDTH cycles,
// LSB first, with a registered borrow chain and a start/done handshake.

module full_sub (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_c;
  assign o_bout = (~i_a & i_b) | (~(i_a ^ i_b) & i_c);

endmodule

// state   | meaning
// IDLE    | waiting for start; operands may be accepted
// RUN     | one bit per cycle through the shared cell, count = bit index
// DONE    | result valid for one cycle, then back to IDLE
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;
  logic             w_accept;
  logic             w_run;
  logic             w_last;
  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_cell_d;
  logic             w_cell_bout;

  assign w_a_bit = r_a[r_cnt];
  assign w_b_bit = r_b[r_cnt];

  full_sub u_cell (
    .i_a    (w_a_bit),
    .i_b    (w_b_bit),
    .i_c    (r_borrow),
    .o_d    (w_cell_d),
    .o_bout (w_cell_bout)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // busy/done come straight from flops so consumers see glitch-free strobes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_done  <= (w_state_nxt == ST_DONE);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
    end else if (w_accept) begin
      r_a      <= i_a;
      r_b      <= i_b;
      r_borrow <= i_bin;
      r_cnt    <= '0;
    end else if (w_run) begin
      r_diff[r_cnt] <= w_cell_d;
      r_borrow      <= w_cell_bout;
      if (w_last) begin
        r_bout <= w_cell_bout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_diff = r_diff;
  assign o_bout = r_bout;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: 8-bit and 1-bit instances, directed table,
// reset abort, busy-start spam and random operands against an arithmetic model.

module tb_serial_sub_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       st8 = 1'b0, st1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       bin8 = 1'b0, a1 = 1'b0, b1 = 1'b0, bin1 = 1'b0;
  logic       busy8, done8, bout8, busy1, done1, bout1;
  logic [7:0] diff8;
  logic [0:0] diff1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st8), .i_a(a8), .i_b(b8), .i_bin(bin8),
    .o_busy(busy8), .o_done(done8), .o_diff(diff8), .o_bout(bout8)
  );

  serial_sub_ctrl #(.WIDTH(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(st1), .i_a(a1), .i_b(b1), .i_bin(bin1),
    .o_busy(busy1), .o_done(done1), .o_diff(diff1), .o_bout(bout1)
  );

  typedef struct {
    bit         w1;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bo;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // plain-integer subtraction, wrapped to w bits; borrow is a < b + bin
  function automatic logic [8:0] ref_sub(input int w, input logic [7:0] a,
                                         input logic [7:0] b, input logic bin);
    int mask, av, bv, bi, r;
    mask = (1 << w) - 1;
    av = int'(a) & mask;
    bv = int'(b) & mask;
    bi = bin ? 1 : 0;
    r  = (av - bv - bi) & mask;
    ref_sub = {(av < bv + bi) ? 1'b1 : 1'b0, 8'(r)};
  endfunction

  task automatic drive(input bit w1, input logic [7:0] a, input logic [7:0] b,
                       input logic bin, input logic s);
    if (w1) begin
      a1 = a[0]; b1 = b[0]; bin1 = bin; st1 = s;
    end else begin
      a8 = a; b8 = b; bin8 = bin; st8 = s;
    end
  endtask

  task automatic op(input bit w1, input logic [7:0] a, input logic [7:0] b, input logic bin,
                    input bit spam, input logic [7:0] exp_d, input logic exp_bo, input string nm);
    int w, lat, nd;
    logic [7:0] gd, cd;
    logic gb, dn, by;
    w = w1 ? 1 : 8;
    lat = -1; nd = 0; gd = '0; gb = 1'b0;
    @(negedge clk);
    drive(w1, a, b, bin, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      if (spam && c <= w + 1)
        drive(w1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      else
        drive(w1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      @(posedge clk);
      #1;
      dn = w1 ? done1 : done8;
      by = w1 ? busy1 : busy8;
      cd = w1 ? {7'b0, diff1} : diff8;
      if (c == 1) check({nm, ".busy_run"}, 32'(by), 32'd1);
      if (c == w + 1) check({nm, ".busy_idle"}, 32'(by), 32'd0);
      if (dn) begin
        nd++;
        if (lat < 0) begin
          lat = c;
          gd  = cd;
          gb  = w1 ? bout1 : bout8;
        end
      end
    end
    check({nm, ".latency"}, 32'(lat), 32'(w));
    check({nm, ".n_done"}, 32'(nd), 32'd1);
    check({nm, ".diff"}, 32'(gd), 32'(exp_d));
    check({nm, ".bout"}, 32'(gb), 32'(exp_bo));
    cd = w1 ? {7'b0, diff1} : diff8;
    check({nm, ".diff_held"}, 32'(cd), 32'(exp_d));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] m;
    logic [7:0] ra, rb;
    logic rbin;
    int nd;

    tbl[0]  = '{1'b0, 8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
    tbl[1]  = '{1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    tbl[2]  = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3]  = '{1'b0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    tbl[5]  = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b1};
    tbl[6]  = '{1'b1, 8'h00, 8'h01, 1'b0, 8'h01, 1'b1};
    tbl[7]  = '{1'b1, 8'h00, 8'h01, 1'b1, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 8'h01, 8'h00, 1'b0, 8'h01, 1'b0};
    tbl[9]  = '{1'b1, 8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0};
    tbl[11] = '{1'b1, 8'h01, 8'h01, 1'b1, 8'h01, 1'b1};

    #3 rst_n = 1'b0;
    #4;
    check("rst.busy8", 32'(busy8), 32'd0);
    check("rst.done8", 32'(done8), 32'd0);
    check("rst.diff8", 32'(diff8), 32'd0);
    check("rst.bout8", 32'(bout8), 32'd0);
    check("rst.busy1", 32'(busy1), 32'd0);
    check("rst.diff1", 32'(diff1), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      op(tbl[i].w1, tbl[i].a, tbl[i].b, tbl[i].bin, 1'b0, tbl[i].d, tbl[i].bo,
         $sformatf("tbl%0d", i));

    op(1'b0, 8'h5A, 8'h3C, 1'b0, 1'b1, 8'h1E, 1'b0, "spam8");
    op(1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1, "spam1");

    // abort in the 4th RUN cycle: partial result must vanish, no done
    @(negedge clk);
    drive(1'b0, 8'hA5, 8'h13, 1'b0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    st8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy8), 32'd0);
    check("abort.done", 32'(done8), 32'd0);
    check("abort.diff", 32'(diff8), 32'd0);
    check("abort.bout", 32'(bout8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nd = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk);
      #1;
      if (done8) nd++;
    end
    check("abort.no_done", 32'(nd), 32'd0);
    check("abort.idle", 32'(busy8), 32'd0);
    op(1'b0, 8'hA5, 8'h13, 1'b0, 1'b0, 8'h92, 1'b0, "after_abort");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      if (i % 5 == 0) ra = 8'($urandom_range(0, 3));
      m = ref_sub(8, ra, rb, rbin);
      op(1'b0, ra, rb, rbin, (i % 4) == 3, m[7:0], m[8], $sformatf("rnd8_%0d", i));
    end
    for (int i = 0; i < 10; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      m = ref_sub(1, ra, rb, rbin);
      op(1'b1, ra, rb, rbin, (i % 3) == 2, m[7:0], m[8], $sformatf("rnd1_%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
